// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: entry field widths, tag width
// derivation and packed-bus slice helpers.
package rob_pkg;

  // Per-entry control flags held in resettable storage.
  typedef struct packed {
    logic busy;
    logic ready;
    logic exc;
  } rob_ctl_t;

  localparam int ROB_CTL_W   = $bits(rob_ctl_t);
  localparam int ROB_STORE_W = 1;
  localparam int ROB_LK_PORTS = 2;

  // Tag width for a given depth; a 2-entry buffer still needs one tag bit.
  function automatic int tag_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Low bit of field idx in a bus packed as idx*width.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around pointer with increment enable; clear has priority over increment.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer value: clear wins, otherwise advance modulo 2**W.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer_pn.sv
// Reorder buffer: in-order allocate, out-of-order completion over NUM_CDB
// result buses, operand lookup with CDB bypass, in-order commit handshake.
module reorder_buffer_pn
  import rob_pkg::*;
#(
  parameter int  DEPTH   = 32,
  parameter int  DATA_W  = 32,
  parameter int  AREG_W  = 5,
  parameter int  NUM_CDB = 2,
  localparam int TAG_W   = tag_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [AREG_W-1:0]           alloc_dest,
  input  logic                        alloc_is_store,
  output logic [TAG_W-1:0]            alloc_tag,
  output logic                        rob_full,
  output logic                        rob_empty,
  output logic [TAG_W:0]              rob_count,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_val,
  input  logic [NUM_CDB-1:0]          cdb_exc,
  input  logic [2*TAG_W-1:0]          lk_tag,
  output logic [1:0]                  lk_ready,
  output logic [2*DATA_W-1:0]         lk_val,
  output logic                        commit_valid,
  output logic [TAG_W-1:0]            commit_tag,
  output logic [AREG_W-1:0]           commit_arch_reg,
  output logic [DATA_W-1:0]           commit_val,
  output logic                        commit_is_store,
  output logic                        commit_exc,
  input  logic                        commit_ack,
  input  logic                        flush
);

  // Control state (reset) and payload state (not reset).
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [DEPTH-1:0]  exc_q, exc_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [TAG_W-1:0]  head_q, tail_q;

  logic [ROB_STORE_W-1:0] store_q [DEPTH];
  logic [AREG_W-1:0]      dest_q  [DEPTH];
  logic [DATA_W-1:0]      val_q   [DEPTH];

  logic              commit_acc;
  logic              exc_kill;
  logic              clear;
  logic              alloc_acc;

  logic [DEPTH-1:0]  cdb_hit;
  logic [DEPTH-1:0]  cdb_wexc;
  logic [DATA_W-1:0] cdb_wval [DEPTH];

  assign rob_full  = (count_q == (TAG_W+1)'(DEPTH));
  assign rob_empty = (count_q == '0);
  assign rob_count = count_q;
  assign alloc_tag = tail_q;

  assign commit_valid    = busy_q[head_q] && ready_q[head_q];
  assign commit_tag      = head_q;
  assign commit_arch_reg = dest_q[head_q];
  assign commit_val      = val_q[head_q];
  assign commit_is_store = store_q[head_q][0];
  assign commit_exc      = exc_q[head_q];

  // Accepted events; an acked exceptional head wipes the buffer like flush,
  // and a full buffer refuses allocation even while the head retires.
  always_comb begin
    commit_acc = commit_valid && commit_ack && !flush;
    exc_kill   = commit_acc && exc_q[head_q];
    clear      = flush || exc_kill;
    alloc_acc  = alloc_valid && !rob_full && !clear;
  end

  // Per-entry CDB write select; scanning from the top port down lets the
  // lowest-indexed port win. Writes to idle or just-allocated entries drop.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      cdb_hit[e]  = 1'b0;
      cdb_wexc[e] = 1'b0;
      cdb_wval[e] = '0;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_valid[p] && (cdb_tag[slice_lo(p, TAG_W) +: TAG_W] == TAG_W'(e))) begin
          cdb_hit[e]  = 1'b1;
          cdb_wexc[e] = cdb_exc[p];
          cdb_wval[e] = cdb_val[slice_lo(p, DATA_W) +: DATA_W];
        end
      end
      if (!busy_q[e] || clear || (alloc_acc && (tail_q == TAG_W'(e)))) begin
        cdb_hit[e] = 1'b0;
      end
    end
  end

  // Next control state: completion, retire, allocate and occupancy.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    exc_d   = exc_q;
    count_d = count_q;
    if (clear) begin
      busy_d  = '0;
      ready_d = '0;
      exc_d   = '0;
      count_d = '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (cdb_hit[e]) begin
          ready_d[e] = 1'b1;
          exc_d[e]   = cdb_wexc[e];
        end
      end
      if (commit_acc) begin
        busy_d[head_q] = 1'b0;
      end
      if (alloc_acc) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        exc_d[tail_q]   = 1'b0;
      end
      count_d = count_q + (TAG_W+1)'(alloc_acc) - (TAG_W+1)'(commit_acc);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      exc_q   <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      exc_q   <= exc_d;
      count_q <= count_d;
    end
  end

  // Payload storage; only meaningful while the matching busy bit is set.
  always_ff @(posedge clk) begin
    if (alloc_acc) begin
      dest_q[tail_q]  <= alloc_dest;
      store_q[tail_q] <= alloc_is_store;
    end
    for (int e = 0; e < DEPTH; e++) begin
      if (cdb_hit[e]) begin
        val_q[e] <= cdb_wval[e];
      end
    end
  end

  // Operand lookup; a result on the CDB this cycle is forwarded directly.
  always_comb begin
    lk_ready = '0;
    lk_val   = '0;
    for (int j = 0; j < ROB_LK_PORTS; j++) begin
      lk_ready[j] = busy_q[lk_tag[slice_lo(j, TAG_W) +: TAG_W]] &&
                    ready_q[lk_tag[slice_lo(j, TAG_W) +: TAG_W]];
      lk_val[slice_lo(j, DATA_W) +: DATA_W] = val_q[lk_tag[slice_lo(j, TAG_W) +: TAG_W]];
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_valid[p] &&
            (cdb_tag[slice_lo(p, TAG_W) +: TAG_W] == lk_tag[slice_lo(j, TAG_W) +: TAG_W])) begin
          lk_ready[j] = 1'b1;
          lk_val[slice_lo(j, DATA_W) +: DATA_W] = cdb_val[slice_lo(p, DATA_W) +: DATA_W];
        end
      end
    end
  end

  rob_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (commit_acc),
    .ptr_o (head_q)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (alloc_acc),
    .ptr_o (tail_q)
  );

endmodule

// File: tb/tb_reorder_buffer_pn.sv
// Bench for reorder_buffer_pn at DEPTH=4, two CDB ports, with a queue-based
// program-order reference model.
module tb_reorder_buffer_pn;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NC    = 2;
  localparam int TW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_dest;
  logic              alloc_is_store;
  logic [TW-1:0]     alloc_tag;
  logic              rob_full, rob_empty;
  logic [TW:0]       rob_count;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_val;
  logic [NC-1:0]     cdb_exc;
  logic [2*TW-1:0]   lk_tag;
  logic [1:0]        lk_ready;
  logic [2*DW-1:0]   lk_val;
  logic              commit_valid;
  logic [TW-1:0]     commit_tag;
  logic [AW-1:0]     commit_arch_reg;
  logic [DW-1:0]     commit_val;
  logic              commit_is_store, commit_exc, commit_ack, flush;

  int checks = 0;
  int failures = 0;

  reorder_buffer_pn #(.DEPTH(DEPTH), .DATA_W(DW), .AREG_W(AW), .NUM_CDB(NC)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_is_store(alloc_is_store), .alloc_tag(alloc_tag), .rob_full(rob_full),
    .rob_empty(rob_empty), .rob_count(rob_count), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_exc(cdb_exc), .lk_tag(lk_tag),
    .lk_ready(lk_ready), .lk_val(lk_val), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .commit_arch_reg(commit_arch_reg),
    .commit_val(commit_val), .commit_is_store(commit_is_store),
    .commit_exc(commit_exc), .commit_ack(commit_ack), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions oldest first.
  typedef struct {
    int          tag;
    logic [AW-1:0] dest;
    bit          st;
    bit          rdy;
    logic [DW-1:0] val;
    bit          exc;
  } ent_t;

  ent_t m_q[$];
  int   m_head = 0;

  function automatic int m_tail();
    return (m_head + m_q.size()) % DEPTH;
  endfunction

  function automatic bit m_commit_valid();
    return (m_q.size() > 0) && m_q[0].rdy;
  endfunction

  // Expected lookup for one tag under current inputs.
  function automatic void m_lookup(input int t, output bit rdy, output logic [DW-1:0] v);
    rdy = 1'b0;
    v = '0;
    for (int p = 0; p < NC; p++) begin
      if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == t) begin
        rdy = 1'b1;
        v = cdb_val[p*DW +: DW];
        return;
      end
    end
    foreach (m_q[k]) begin
      if (m_q[k].tag == t && m_q[k].rdy) begin
        rdy = 1'b1;
        v = m_q[k].val;
      end
    end
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_update();
    bit cacc, eacc, aacc;
    int nt;
    ent_t ne;
    if (rst || flush) begin
      m_q.delete();
      m_head = 0;
      return;
    end
    cacc = m_commit_valid() && commit_ack;
    eacc = cacc && m_q[0].exc;
    aacc = alloc_valid && (m_q.size() < DEPTH) && !eacc;
    nt = m_tail();
    foreach (m_q[k]) begin
      for (int p = 0; p < NC; p++) begin
        if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == m_q[k].tag) begin
          m_q[k].rdy = 1'b1;
          m_q[k].val = cdb_val[p*DW +: DW];
          m_q[k].exc = cdb_exc[p];
          break;
        end
      end
    end
    if (eacc) begin
      m_q.delete();
      m_head = 0;
    end else begin
      if (cacc) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (aacc) begin
        ne.tag = nt; ne.dest = alloc_dest; ne.st = alloc_is_store;
        ne.rdy = 1'b0; ne.val = '0; ne.exc = 1'b0;
        m_q.push_back(ne);
      end
    end
  endfunction

  task automatic idle();
    alloc_valid = 0; alloc_dest = '0; alloc_is_store = 0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0; cdb_exc = '0;
    lk_tag = '0; commit_ack = 0; flush = 0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1;
    repeat (3) step();
    rst = 0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; alloc_dest = AW'(i + 1); alloc_is_store = i[0];
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 5;
    if (rob_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", rob_empty); end
    if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", rob_full); end
    if (alloc_tag !== '0) begin failures++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
    if (rob_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rob_count); end
  endtask

  task automatic test_fill();
    reset_dut();
    for (int k = 1; k <= 5; k++) begin
      alloc_valid = 1; alloc_dest = AW'(k);
      #1;
      checks += 2;
      if (alloc_tag !== TW'((k - 1) % DEPTH)) begin failures++; $display("FAIL fill_tag k=%0d got=%0d exp=%0d", k, alloc_tag, (k - 1) % DEPTH); end
      if (rob_full !== (k == 5)) begin failures++; $display("FAIL fill_full k=%0d got=%0b exp=%0b", k, rob_full, k == 5); end
      step();
    end
    idle();
    checks += 3;
    if (rob_full !== 1'b1) begin failures++; $display("FAIL fill_full_end got=%0b exp=1", rob_full); end
    if (rob_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", rob_count); end
    if (alloc_tag !== 2'd0) begin failures++; $display("FAIL fill_alloc_tag got=%0d exp=0", alloc_tag); end
  endtask

  task automatic test_cdb_priority();
    reset_dut();
    alloc_n(4);
    cdb_valid = 2'b11; cdb_tag = {2'd0, 2'd0}; cdb_val = {32'h1, 32'hDEADBEEF};
    step();
    idle();
    checks += 3;
    if (commit_valid !== 1'b1) begin failures++; $display("FAIL prio_commit_valid got=%0b exp=1", commit_valid); end
    if (commit_val !== 32'hDEADBEEF) begin failures++; $display("FAIL prio_commit_val got=%h exp=deadbeef", commit_val); end
    if (commit_arch_reg !== 5'd1) begin failures++; $display("FAIL prio_commit_reg got=%0d exp=1", commit_arch_reg); end
    commit_ack = 1; alloc_valid = 1; alloc_dest = 5'd9;
    step();
    idle();
    checks += 4;
    if (commit_tag !== 2'd1) begin failures++; $display("FAIL prio_head got=%0d exp=1", commit_tag); end
    if (rob_count !== 3'd3) begin failures++; $display("FAIL prio_count got=%0d exp=3", rob_count); end
    if (alloc_tag !== 2'd0) begin failures++; $display("FAIL prio_full_reject_tag got=%0d exp=0", alloc_tag); end
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL prio_next_valid got=%0b exp=0", commit_valid); end
  endtask

  task automatic test_in_order();
    reset_dut();
    alloc_n(2);
    cdb_valid = 2'b01; cdb_tag = {2'd0, 2'd1}; cdb_val = {32'h0, 32'h11};
    step();
    idle();
    checks++;
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL order_blocked got=%0b exp=0", commit_valid); end
    cdb_valid = 2'b01; cdb_tag = {2'd0, 2'd0}; cdb_val = {32'h0, 32'h10};
    step();
    idle();
    checks += 3;
    if (commit_valid !== 1'b1) begin failures++; $display("FAIL order_v0 got=%0b exp=1", commit_valid); end
    if (commit_tag !== 2'd0) begin failures++; $display("FAIL order_tag0 got=%0d exp=0", commit_tag); end
    if (commit_val !== 32'h10) begin failures++; $display("FAIL order_val0 got=%h exp=10", commit_val); end
    commit_ack = 1;
    step();
    checks += 3;
    if (commit_valid !== 1'b1) begin failures++; $display("FAIL order_v1 got=%0b exp=1", commit_valid); end
    if (commit_tag !== 2'd1) begin failures++; $display("FAIL order_tag1 got=%0d exp=1", commit_tag); end
    if (commit_val !== 32'h11) begin failures++; $display("FAIL order_val1 got=%h exp=11", commit_val); end
    step();
    idle();
    checks++;
    if (rob_empty !== 1'b1) begin failures++; $display("FAIL order_empty got=%0b exp=1", rob_empty); end
  endtask

  task automatic test_lookup_bypass();
    reset_dut();
    alloc_n(3);
    lk_tag = {2'd1, 2'd2};
    cdb_valid = 2'b10; cdb_tag = {2'd2, 2'd2}; cdb_val = {32'h55, 32'h99};
    #1;
    checks += 3;
    if (lk_ready[0] !== 1'b1) begin failures++; $display("FAIL byp_ready got=%0b exp=1", lk_ready[0]); end
    if (lk_val[31:0] !== 32'h55) begin failures++; $display("FAIL byp_val got=%h exp=55", lk_val[31:0]); end
    if (lk_ready[1] !== 1'b0) begin failures++; $display("FAIL byp_other_ready got=%0b exp=0", lk_ready[1]); end
    step();
    cdb_valid = '0;
    #1;
    checks += 2;
    if (lk_ready[0] !== 1'b1) begin failures++; $display("FAIL lk_stored_ready got=%0b exp=1", lk_ready[0]); end
    if (lk_val[31:0] !== 32'h55) begin failures++; $display("FAIL lk_stored_val got=%h exp=55", lk_val[31:0]); end
    idle();
  endtask

  task automatic test_exception();
    reset_dut();
    alloc_n(4);
    cdb_valid = 2'b01; cdb_tag = '0; cdb_val = {32'h0, 32'hBAD}; cdb_exc = 2'b01;
    step();
    idle();
    checks += 2;
    if (commit_valid !== 1'b1) begin failures++; $display("FAIL exc_valid got=%0b exp=1", commit_valid); end
    if (commit_exc !== 1'b1) begin failures++; $display("FAIL exc_flag got=%0b exp=1", commit_exc); end
    commit_ack = 1; alloc_valid = 1;
    step();
    idle();
    checks += 4;
    if (rob_empty !== 1'b1) begin failures++; $display("FAIL exc_empty got=%0b exp=1", rob_empty); end
    if (rob_count !== '0) begin failures++; $display("FAIL exc_count got=%0d exp=0", rob_count); end
    if (alloc_tag !== '0) begin failures++; $display("FAIL exc_tail got=%0d exp=0", alloc_tag); end
    if (commit_tag !== '0) begin failures++; $display("FAIL exc_head got=%0d exp=0", commit_tag); end
  endtask

  task automatic test_flush();
    reset_dut();
    alloc_n(2);
    cdb_valid = 2'b01; cdb_tag = '0; cdb_val = {32'h0, 32'h7};
    step();
    idle();
    flush = 1; alloc_valid = 1; commit_ack = 1;
    step();
    idle();
    checks += 3;
    if (rob_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b exp=1", rob_empty); end
    if (rob_count !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", rob_count); end
    if (alloc_tag !== '0) begin failures++; $display("FAIL flush_tail got=%0d exp=0", alloc_tag); end
    alloc_n(1);
    checks++;
    if (rob_count !== 3'd1) begin failures++; $display("FAIL flush_after_alloc got=%0d exp=1", rob_count); end
  endtask

  task automatic test_random();
    bit r0, r1;
    logic [DW-1:0] v0, v1;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_dest = AW'($urandom);
      alloc_is_store = $urandom_range(0, 1);
      for (int p = 0; p < NC; p++) begin
        cdb_valid[p] = $urandom_range(0, 1);
        cdb_tag[p*TW +: TW] = TW'($urandom_range(0, DEPTH - 1));
        cdb_val[p*DW +: DW] = $urandom;
        cdb_exc[p] = ($urandom_range(0, 7) == 0);
      end
      lk_tag = 4'($urandom);
      commit_ack = $urandom_range(0, 1);
      flush = ($urandom_range(0, 39) == 0);
      #1;
      m_lookup(int'(lk_tag[1:0]), r0, v0);
      m_lookup(int'(lk_tag[3:2]), r1, v1);
      checks += 7;
      if (rob_count !== 3'(m_q.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, rob_count, m_q.size()); end
      if (rob_full !== (m_q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full c=%0d got=%0b", c, rob_full); end
      if (rob_empty !== (m_q.size() == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%0b", c, rob_empty); end
      if (alloc_tag !== TW'(m_tail())) begin failures++; $display("FAIL rnd_tail c=%0d got=%0d exp=%0d", c, alloc_tag, m_tail()); end
      if (commit_valid !== m_commit_valid()) begin failures++; $display("FAIL rnd_commit_valid c=%0d got=%0b exp=%0b", c, commit_valid, m_commit_valid()); end
      if (lk_ready[0] !== r0) begin failures++; $display("FAIL rnd_lk0_ready c=%0d got=%0b exp=%0b", c, lk_ready[0], r0); end
      if (lk_ready[1] !== r1) begin failures++; $display("FAIL rnd_lk1_ready c=%0d got=%0b exp=%0b", c, lk_ready[1], r1); end
      if (r0) begin
        checks++;
        if (lk_val[31:0] !== v0) begin failures++; $display("FAIL rnd_lk0_val c=%0d got=%h exp=%h", c, lk_val[31:0], v0); end
      end
      if (r1) begin
        checks++;
        if (lk_val[63:32] !== v1) begin failures++; $display("FAIL rnd_lk1_val c=%0d got=%h exp=%h", c, lk_val[63:32], v1); end
      end
      if (m_commit_valid()) begin
        checks += 5;
        if (commit_tag !== TW'(m_q[0].tag)) begin failures++; $display("FAIL rnd_ctag c=%0d got=%0d exp=%0d", c, commit_tag, m_q[0].tag); end
        if (commit_arch_reg !== m_q[0].dest) begin failures++; $display("FAIL rnd_creg c=%0d got=%0d exp=%0d", c, commit_arch_reg, m_q[0].dest); end
        if (commit_val !== m_q[0].val) begin failures++; $display("FAIL rnd_cval c=%0d got=%h exp=%h", c, commit_val, m_q[0].val); end
        if (commit_is_store !== m_q[0].st) begin failures++; $display("FAIL rnd_cst c=%0d got=%0b exp=%0b", c, commit_is_store, m_q[0].st); end
        if (commit_exc !== m_q[0].exc) begin failures++; $display("FAIL rnd_cexc c=%0d got=%0b exp=%0b", c, commit_exc, m_q[0].exc); end
      end
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_fill();
    test_cdb_priority();
    test_in_order();
    test_lookup_bypass();
    test_exception();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
